// File: rtl/skewbuf_pkg.sv
// Shared helpers for the skewed input buffer: pointer width and the lane payload type.
// Optional build macro used by this slice: SKEWBUF_ZERO_FILL_EN.
package skewbuf_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Payload carried down a lane's skew line at the default lane width.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } lane_t;

endpackage

// File: rtl/skew_delay.sv
// Per-lane skew line: STAGES registers of {valid,data}; with STAGES==0 it is a plain wire.
// Used by skew_inbuf_array (optional build macro: SKEWBUF_ZERO_FILL_EN, handled by the top).
module skew_delay
    import skewbuf_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_clk_rstn;
            assign unused_clk_rstn = clk ^ rstn;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            stage_t pipe [STAGES];

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= stage_t'{valid: in_valid, data: in_data};
                    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign out_valid = pipe[STAGES-1].valid;
            assign out_data  = pipe[STAGES-1].data;
        end
    endgenerate

endmodule

// File: rtl/skew_inbuf_array.sv
// Lockstep multi-lane FIFO whose lane c output is delayed by c*SKEW_STEP cycles (diagonal wavefront).
// Build macro SKEWBUF_ZERO_FILL_EN: lanes with dvalid=0 drive zero instead of holding last data.
module skew_inbuf_array
    import skewbuf_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int SKEW_STEP = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      write,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      read,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dvalid,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]             wptr, rptr;
    logic [CW-1:0]             count;
    logic                      rd_acc, wr_acc;
    logic                      rd_valid_q;
    logic [CHANNELS*WIDTH-1:0] rd_data_q;

    // Handshake: a pop happens when read is high and the FIFO is not empty; a push happens
    // when write is high and the FIFO is not full, or is full but a pop frees a slot this cycle.
    // A push into an empty FIFO is only readable from the following cycle.
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign rd_acc = read && !empty;
    assign wr_acc = write && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count <= count + CW'(wr_acc) - CW'(rd_acc);
            if (write && !wr_acc) overflow <= 1'b1;
            rd_valid_q <= rd_acc;
            // Data is kept on a bubble so hold-mode lanes keep showing their last word.
            if (rd_acc) rd_data_q <= mem[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_acc) mem[wptr] <= din;
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
            logic             lane_valid;
            logic [WIDTH-1:0] lane_data;

            skew_delay #(
                .WIDTH (WIDTH),
                .STAGES(c * SKEW_STEP)
            ) u_delay (
                .clk      (clk),
                .rstn     (rstn),
                .in_valid (rd_valid_q),
                .in_data  (rd_data_q[c*WIDTH +: WIDTH]),
                .out_valid(lane_valid),
                .out_data (lane_data)
            );

            assign dvalid[c] = lane_valid;
`ifdef SKEWBUF_ZERO_FILL_EN
            assign dout[c*WIDTH +: WIDTH] = lane_valid ? lane_data : '0;
`else
            assign dout[c*WIDTH +: WIDTH] = lane_data;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_skew_inbuf_array.sv
// Directed bench for skew_inbuf_array (CHANNELS=3, DEPTH=4, SKEW_STEP=1, WIDTH=8) with a queue model.
module tb_skew_inbuf_array;

    localparam int W = 8;
    localparam int D = 4;
    localparam int C = 3;
`ifdef SKEWBUF_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn, write, read;
    logic [C*W-1:0] din, dout;
    logic [C-1:0]   dvalid;
    logic           empty, full, overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    skew_inbuf_array #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .SKEW_STEP(1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .write   (write),
        .din     (din),
        .read    (read),
        .dout    (dout),
        .dvalid  (dvalid),
        .empty   (empty),
        .full    (full),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a word queue for the FIFO plus, per lane, the pop event that lane is currently showing.
    logic [C*W-1:0] m_q[$];
    logic           m_hv [C];
    logic [C*W-1:0] m_hd [C];
    logic [W-1:0]   m_hold [C];
    logic           m_ovf = 1'b0;
    bit             model_live = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_q.delete();
            for (int c = 0; c < C; c++) begin
                m_hv[c]   = 1'b0;
                m_hd[c]   = '0;
                m_hold[c] = '0;
            end
            m_ovf      = 1'b0;
            model_live = 1'b1;
        end else begin
            bit rd, wr;
            logic [C*W-1:0] w;
            rd = read && (m_q.size() > 0);
            wr = write && ((m_q.size() < D) || rd);
            if (write && !wr) m_ovf = 1'b1;
            w = '0;
            if (rd) w = m_q.pop_front();
            for (int c = C - 1; c > 0; c--) begin
                m_hv[c] = m_hv[c-1];
                m_hd[c] = m_hd[c-1];
            end
            m_hv[0] = rd;
            m_hd[0] = w;
            if (wr) m_q.push_back(din);
            for (int c = 0; c < C; c++)
                if (m_hv[c]) m_hold[c] = m_hd[c][c*W +: W];
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic [C-1:0]   e_dv;
            logic [C*W-1:0] e_do;
            for (int c = 0; c < C; c++) begin
                e_dv[c] = m_hv[c];
                if (m_hv[c])  e_do[c*W +: W] = m_hd[c][c*W +: W];
                else if (ZF)  e_do[c*W +: W] = '0;
                else          e_do[c*W +: W] = m_hold[c];
            end
            check("model_dvalid", 32'(dvalid), 32'(e_dv));
            check("model_dout", 32'(dout), 32'(e_do));
            check("model_empty", 32'(empty), 32'(m_q.size() == 0));
            check("model_full", 32'(full), 32'(m_q.size() == D));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    logic [W-1:0] exp_q[$];

    initial begin
        rstn = 1'b0; write = 1'b0; read = 1'b0; din = '0;
        step(); step();
        rstn = 1'b1;
        check("rst_dout", 32'(dout), 0);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Skew: one word walks diagonally across the lanes.
        write = 1'b1; din = 24'h030201; step();
        write = 1'b0; read = 1'b1; step();
        read = 1'b0;
        check("skew_dv0", 32'(dvalid), 32'h1);
        check("skew_l0", 32'(dout[7:0]), 1);
        step();
        check("skew_dv1", 32'(dvalid), 32'h2);
        check("skew_l1", 32'(dout[15:8]), 2);
        step();
        check("skew_dv2", 32'(dvalid), 32'h4);
        check("skew_l2", 32'(dout[23:16]), 3);
        step();
        check("skew_dv_end", 32'(dvalid), 0);
        check("skew_idle_dout", 32'(dout), ZF ? 32'h0 : 32'h030201);

        // Fill past capacity, then drain.
        for (int n = 1; n <= 5; n++) begin
            write = 1'b1; din = {3{8'(n)}}; step();
            if (n == 4) check("fill_full4", 32'(full), 1);
        end
        write = 1'b0;
        check("fill_overflow", 32'(overflow), 1);
        check("fill_full", 32'(full), 1);
        for (int n = 1; n <= 4; n++) exp_q.push_back(8'(n));
        read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_v0", 32'(dvalid[0]), 1);
            check("drain_l0", 32'(dout[7:0]), 32'(exp_q.pop_front()));
        end
        read = 1'b0;
        check("drain_empty", 32'(empty), 1);
        step(); step(); step();

        rstn = 1'b0; step(); rstn = 1'b1;
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_empty", 32'(empty), 1);

        // Full with simultaneous read and write.
        for (int n = 1; n <= 4; n++) begin
            write = 1'b1; din = {3{8'(n)}}; step();
        end
        din = 24'h090909; read = 1'b1; step();
        write = 1'b0;
        check("frw_full", 32'(full), 1);
        check("frw_overflow", 32'(overflow), 0);
        check("frw_l0_first", 32'(dout[7:0]), 1);
        exp_q.push_back(8'd2); exp_q.push_back(8'd3);
        exp_q.push_back(8'd4); exp_q.push_back(8'd9);
        for (int i = 0; i < 4; i++) begin
            step();
            check("frw_v0", 32'(dvalid[0]), 1);
            check("frw_l0", 32'(dout[7:0]), 32'(exp_q.pop_front()));
        end
        read = 1'b0;
        check("frw_empty", 32'(empty), 1);
        step(); step(); step();

        // Reads against an empty FIFO produce only bubbles.
        read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("er_dvalid", 32'(dvalid), 0);
            check("er_empty", 32'(empty), 1);
            check("er_dout", 32'(dout), ZF ? 32'h0 : 32'h090909);
        end
        read = 1'b0;

        // Reset while a word is in the skew line.
        write = 1'b1; din = 24'h050505; step();
        din = 24'h060606; step();
        write = 1'b0; read = 1'b1; step();
        read = 1'b0; rstn = 1'b0; step();
        rstn = 1'b1;
        check("mrst_dvalid", 32'(dvalid), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dout", 32'(dout), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_no_stale_dv", 32'(dvalid), 0);
            check("mrst_no_stale_dout", 32'(dout), 0);
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
